// File: rtl/n64_joybus_pkg.sv
//------------------------------------------------------------------------------
// Module   : n64_joybus_pkg
// Brief    : Joybus command codes, expected-length table and sequencer states.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package n64_joybus_pkg;

  localparam logic [7:0] c_CMD_INFO   = 8'h00;
  localparam logic [7:0] c_CMD_STATUS = 8'h01;
  localparam logic [7:0] c_CMD_READ   = 8'h02;
  localparam logic [7:0] c_CMD_WRITE  = 8'h03;
  localparam logic [7:0] c_CMD_RESET  = 8'hFF;

  // Byte counts include the command byte itself.
  localparam logic [5:0] c_LEN_INFO    = 6'd1;
  localparam logic [5:0] c_LEN_STATUS  = 6'd1;
  localparam logic [5:0] c_LEN_RESET   = 6'd1;
  localparam logic [5:0] c_LEN_READ    = 6'd3;
  localparam logic [5:0] c_LEN_WRITE   = 6'd35;
  localparam logic [5:0] c_LEN_DEFAULT = 6'd1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_COLLECT    = 2'd1,
    ST_TURNAROUND = 2'd2,
    ST_TRANSMIT   = 2'd3
  } seq_state_t;

  function automatic logic [5:0] expected_len(input logic [7:0] cmd_code);
    case (cmd_code)
      c_CMD_INFO:   expected_len = c_LEN_INFO;
      c_CMD_STATUS: expected_len = c_LEN_STATUS;
      c_CMD_RESET:  expected_len = c_LEN_RESET;
      c_CMD_READ:   expected_len = c_LEN_READ;
      c_CMD_WRITE:  expected_len = c_LEN_WRITE;
      default:      expected_len = c_LEN_DEFAULT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/n64_cmd_length_decoder.sv
//------------------------------------------------------------------------------
// Module   : n64_cmd_length_decoder
// Brief    : Combinational map from command byte to expected host byte count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module n64_cmd_length_decoder
  import n64_joybus_pkg::*;
(
  input  logic [7:0] i_cmd,
  output logic [5:0] o_expected_len
);

  assign o_expected_len = expected_len(i_cmd);

endmodule

`default_nettype wire

// File: rtl/n64_bus_sequencer.sv
//------------------------------------------------------------------------------
// Module   : n64_bus_sequencer
// Brief    : Joybus transaction sequencer: collect, turnaround, transmit handoff.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module n64_bus_sequencer
  import n64_joybus_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 16,
  parameter int BYTE_GAP_TIMEOUT  = 64,
  parameter int TX_TIMEOUT        = 4096
) (
  input  logic       sample_clk,
  input  logic       reset_n,
  input  logic       rx_byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_stop,
  input  logic [7:0] rx_crc,
  input  logic       tx_handoff,
  output logic       cur_operation,
  output logic [7:0] cmd,
  output logic [7:0] crc,
  output logic [7:0] frame_cnt,
  output logic       err
);

  localparam int          c_TIMER_W = 13;
  localparam logic [12:0] c_TA_LAST  = 13'(TURNAROUND_CYCLES - 1);
  localparam logic [12:0] c_GAP_LAST = 13'(BYTE_GAP_TIMEOUT - 1);
  localparam logic [12:0] c_TX_LAST  = 13'(TX_TIMEOUT - 1);

  seq_state_t             r_state, w_state_nxt;
  logic [c_TIMER_W-1:0]   r_timer;
  logic [5:0]             r_byte_cnt, w_cnt_nxt, w_cnt_inc, w_cnt_counted;
  logic [5:0]             w_expected_len;
  logic                   r_baseline;
  logic                   w_err_nxt, w_load_cmd, w_load_crc, w_frame_inc;
  logic                   w_capture_base, w_timer_clr;

  n64_cmd_length_decoder u_len_dec (
    .i_cmd          (cmd),
    .o_expected_len (w_expected_len)
  );

  assign w_cnt_inc     = (r_byte_cnt == 6'd63) ? r_byte_cnt : r_byte_cnt + 6'd1;
  // A byte arriving with the stop is counted before the length check.
  assign w_cnt_counted = rx_byte_valid ? w_cnt_inc : r_byte_cnt;
  assign cur_operation = (r_state == ST_TRANSMIT);

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_err_nxt      = 1'b0;
    w_load_cmd     = 1'b0;
    w_load_crc     = 1'b0;
    w_frame_inc    = 1'b0;
    w_capture_base = 1'b0;
    w_timer_clr    = 1'b0;
    w_cnt_nxt      = r_byte_cnt;
    case (r_state)
      ST_IDLE: begin
        if (rx_byte_valid) begin
          w_load_cmd  = 1'b1;
          w_cnt_nxt   = 6'd1;
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        w_cnt_nxt   = w_cnt_counted;
        w_timer_clr = rx_byte_valid;
        if (rx_stop) begin
          if (w_cnt_counted == w_expected_len) begin
            w_load_crc  = 1'b1;
            w_state_nxt = ST_TURNAROUND;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (!rx_byte_valid && r_timer == c_GAP_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TURNAROUND: begin
        if (r_timer == c_TA_LAST) begin
          w_capture_base = 1'b1;
          w_state_nxt    = ST_TRANSMIT;
        end
      end
      ST_TRANSMIT: begin
        if (tx_handoff != r_baseline) begin
          w_frame_inc = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == c_TX_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd        <= 8'h00;
      crc        <= 8'h00;
      frame_cnt  <= 8'h00;
      err        <= 1'b0;
      r_byte_cnt <= 6'd0;
      r_timer    <= '0;
      r_baseline <= 1'b0;
    end else begin
      err        <= w_err_nxt;
      r_byte_cnt <= w_cnt_nxt;
      if (w_load_cmd)     cmd        <= rx_byte;
      if (w_load_crc)     crc        <= rx_crc;
      if (w_frame_inc)    frame_cnt  <= frame_cnt + 8'd1;
      if (w_capture_base) r_baseline <= tx_handoff;
      // Timer restarts on every state change and idles at zero.
      if (w_state_nxt != r_state || w_timer_clr || r_state == ST_IDLE)
        r_timer <= '0;
      else
        r_timer <= r_timer + 13'd1;
    end
  end

endmodule

`default_nettype wire

// File: doc/n64_bus_sequencer.md
N64_BUS_SEQUENCER -- requirements
Module: n64_bus_sequencer

Interface
REQ-001 The block SHALL have parameter TURNAROUND_CYCLES, default 16: sample_clk cycles between the host stop bit and the start of the response.
REQ-002 The block SHALL have parameter BYTE_GAP_TIMEOUT, default 64: maximum sample_clk cycles between host bytes.
REQ-003 The block SHALL have parameter TX_TIMEOUT, default 4096: maximum sample_clk cycles the transmitter may hold the line.
REQ-004 The block SHALL have port sample_clk  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port rx_byte_valid  in  1  one-cycle pulse: host byte received.
REQ-007 The block SHALL have port rx_byte  in  8  host byte, valid with rx_byte_valid.
REQ-008 The block SHALL have port rx_stop  in  1  one-cycle pulse: host stop bit detected.
REQ-009 The block SHALL have port rx_crc  in  8  running data CRC from the receiver, valid with rx_stop.
REQ-010 The block SHALL have port tx_handoff  in  1  transmitter toggle, indicating that the response is finished.
REQ-011 The block SHALL have port cur_operation  out  1  bus direction: 0 = receive, 1 = transmit.
REQ-012 The block SHALL have port cmd  out  8  latched command byte for the transmitter.
REQ-013 The block SHALL have port crc  out  8  latched CRC seed for the transmitter.
REQ-014 The block SHALL have port frame_cnt  out  8  count of completed transactions, wrapping.
REQ-015 The block SHALL have port err  out  1  one-cycle pulse on any protocol error.

Function
REQ-016 The block SHALL implement states IDLE, COLLECT, TURNAROUND and TRANSMIT, all registered on the rising edge of sample_clk.
REQ-017 In IDLE, rx_byte_valid SHALL latch rx_byte into cmd, set byte_cnt=1, and go to COLLECT.
REQ-018 The expected length SHALL be derived from cmd: 0x00/0x01/0xFF -> 1; 0x02 -> 3; 0x03 -> 35; any other value -> 1.
REQ-019 In COLLECT, each rx_byte_valid SHALL increment byte_cnt (6 bits), saturating at 63.
REQ-020 In COLLECT, rx_stop with byte_cnt == expected SHALL latch rx_crc into crc and go to TURNAROUND.
REQ-021 In COLLECT, rx_stop with byte_cnt != expected SHALL pulse err and return to IDLE; cmd and crc SHALL be held.
REQ-022 When rx_byte_valid and rx_stop occur in the same cycle, the byte SHALL be counted before the length check is made.
REQ-023 In COLLECT, BYTE_GAP_TIMEOUT cycles without rx_byte_valid or rx_stop SHALL pulse err and return to IDLE.
REQ-024 TURNAROUND SHALL last exactly TURNAROUND_CYCLES cycles; cur_operation SHALL then go to 1 on the cycle of entry to TRANSMIT.
REQ-025 On entry to TRANSMIT, the current tx_handoff level SHALL be captured as the baseline.
REQ-026 In TRANSMIT, tx_handoff differing from the baseline SHALL cause cur_operation to go to 0, frame_cnt to increment (255 -> 0), and a return to IDLE, all on the next edge.
REQ-027 In TRANSMIT, TX_TIMEOUT cycles without a handoff SHALL cause cur_operation to go to 0, err to pulse, and a return to IDLE; frame_cnt SHALL NOT change.
REQ-028 rx_byte_valid and rx_stop SHALL be ignored in TURNAROUND and TRANSMIT.
REQ-029 cur_operation SHALL be 1 only in TRANSMIT.
REQ-030 A single shared timer of at least 13 bits SHALL serve all states and SHALL clear on every state change.

Reset
REQ-031 While reset_n=0, the block SHALL be in state IDLE with cur_operation=0, cmd=0x00, crc=0x00, frame_cnt=0, err=0, byte_cnt=0, timer=0 and baseline=0.
REQ-032 Reset asserted mid-TRANSMIT SHALL force cur_operation=0 immediately, asynchronously.
REQ-033 Operation SHALL resume on the first rising edge after reset_n rises.

Structure
REQ-034 Command codes (0x00, 0x01, 0x02, 0x03, 0xFF), the expected-length table and the state encodings SHALL reside in the shared package n64_joybus_pkg.
REQ-035 The block SHALL contain one sub-module, n64_cmd_length_decoder: combinational, cmd -> expected byte count.

Verification
REQ-036 Reset, then cmd 0x01 and stop -> cur_operation=1 exactly 16 cycles after stop; tx_handoff toggle -> cur_operation=0 next edge and frame_cnt=1.
REQ-037 cmd 0x03 plus 34 bytes, then stop with rx_crc=0x5A -> crc=0x5A and TRANSMIT entered; with 33 bytes -> err pulse and IDLE.
REQ-038 cmd 0x02 with the third byte and stop in the same cycle -> TURNAROUND, no err.
REQ-039 cmd 0x02, one byte, then 64 idle cycles -> err on cycle 64 and IDLE; the following cmd 0x00 is accepted normally.
REQ-040 TRANSMIT with no toggle -> after 4096 cycles cur_operation=0, err pulse, frame_cnt unchanged.
REQ-041 256 good transactions -> frame_cnt wraps to 0; reset_n low mid-TRANSMIT -> cur_operation=0 without a clock edge.
